// File: rtl/irq_rr_controller_pkg.sv
// Shared constants for the round-robin interrupt controller: FSM state
// encodings and the width of the post-acknowledge holdoff counter.
package irq_rr_controller_pkg;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ASSERT = 2'd1;
   localparam logic [1:0] HOLD   = 2'd2;

   localparam int HOLD_W = 4;

endpackage

// File: rtl/irq_pending_flag.sv
// Single pending bit: synchronous reset, set wins over clear so a request
// arriving in the acknowledge cycle is never lost.
module irq_pending_flag (
   input  logic clk,
   input  logic rst,
   input  logic set,
   input  logic clr,
   output logic flag
);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst)
         flag <= 1'b0;
      else if (set)
         flag <= 1'b1;
      else if (clr)
         flag <= 1'b0;
   end

endmodule

// File: rtl/irq_rr_controller.sv
// Latches interrupt request pulses, arbitrates them round-robin, and drives a
// single registered interrupt line plus vector with a holdoff after each ack.
module irq_rr_controller
   import irq_rr_controller_pkg::*;
#(
   parameter int N_SRC   = 4,
   parameter int VEC_W   = 2,
   parameter int HOLDOFF = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_SRC-1:0]  irq_set,
   input  logic [N_SRC-1:0]  irq_mask,
   input  logic              intr_ack,
   output logic              intr,
   output logic [VEC_W-1:0]  vector,
   output logic [N_SRC-1:0]  pending,
   output logic              busy
);

   logic [1:0]        state;
   logic [HOLD_W-1:0] hold_cnt;
   logic [VEC_W-1:0]  rr_ptr;
   logic [VEC_W-1:0]  winner;
   logic [VEC_W-1:0]  next_ptr;
   logic              found;
   logic [N_SRC-1:0]  eligible;
   logic [N_SRC-1:0]  clr;

   for (genvar i = 0; i < N_SRC; i++) begin : g_flag
      irq_pending_flag u_flag (
         .clk  (clk),
         .rst  (rst),
         .set  (irq_set[i]),
         .clr  (clr[i]),
         .flag (pending[i])
      );
   end

   assign eligible = pending & irq_mask;
   assign busy     = (state == ASSERT) || (state == HOLD);
   assign next_ptr = (vector == VEC_W'(N_SRC - 1)) ? '0 : vector + 1'b1;

   // Only an ack while asserting clears anything; stray acks are harmless.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // leaves it unassigned and infers a latch.
      clr = '0;
      if (state == ASSERT && intr_ack)
         clr[vector] = 1'b1;
   end

   // Scan from rr_ptr upward with wrap; the first eligible source wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int k = 0; k < N_SRC; k++) begin
         if (!found && eligible[(int'(rr_ptr) + k) % N_SRC]) begin
            found  = 1'b1;
            winner = VEC_W'((int'(rr_ptr) + k) % N_SRC);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         intr     <= 1'b0;
         vector   <= '0;
         rr_ptr   <= '0;
         hold_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  vector <= winner;
                  intr   <= 1'b1;
                  state  <= ASSERT;
               end
            end
            ASSERT: begin
               if (intr_ack) begin
                  intr     <= 1'b0;
                  rr_ptr   <= next_ptr;
                  hold_cnt <= HOLD_W'(HOLDOFF);
                  state    <= (HOLDOFF == 0) ? IDLE : HOLD;
               end
            end
            HOLD: begin
               // Leaving on the count of one gives exactly HOLDOFF idle cycles.
               if (hold_cnt <= HOLD_W'(1)) begin
                  hold_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_irq_rr_controller.sv
// Directed bench for irq_rr_controller: stimulus queues expected vectors and a
// negedge monitor compares them on every rising edge of intr.
module tb_irq_rr_controller;

   localparam int N_SRC   = 4;
   localparam int VEC_W   = 2;
   localparam int HOLDOFF = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [N_SRC-1:0]  irq_set;
   logic [N_SRC-1:0]  irq_mask;
   logic              intr_ack;
   logic              intr;
   logic [VEC_W-1:0]  vector;
   logic [N_SRC-1:0]  pending;
   logic              busy;

   int n_checks = 0;
   int n_errors = 0;
   logic [VEC_W-1:0] exp_q[$];
   logic intr_q = 1'b0;

   irq_rr_controller #(.N_SRC(N_SRC), .VEC_W(VEC_W), .HOLDOFF(HOLDOFF)) dut (
      .clk      (clk),
      .rst      (rst),
      .irq_set  (irq_set),
      .irq_mask (irq_mask),
      .intr_ack (intr_ack),
      .intr     (intr),
      .vector   (vector),
      .pending  (pending),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every intr rising edge must match the next queued vector.
   always @(negedge clk) begin
      if (intr && !intr_q) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_intr: got vector %0d expected no interrupt", vector);
         end else begin
            check("sb_vector", 32'(vector), 32'(exp_q.pop_front()));
         end
      end
      intr_q = intr;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_ack();
      intr_ack = 1'b1;
      tick();
      intr_ack = 1'b0;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      irq_set  = '0;
      intr_ack = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_intr(input string name, output int n);
      n = 0;
      while (!intr && n < 40) begin
         tick();
         n++;
      end
      if (!intr) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: got no intr expected intr within 40 cycles", name);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 40) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      irq_mask = '0;
      do_reset();
      check("reset_intr", 32'(intr), 0);
      check("reset_vector", 32'(vector), 0);
      check("reset_pending", 32'(pending), 0);
      check("reset_busy", 32'(busy), 0);

      // Reset in the middle of an assertion drops the request.
      irq_mask = 4'b1111;
      irq_set  = 4'b0100;
      exp_q.push_back(2);
      tick();
      irq_set = '0;
      check("rst_mid_pending", 32'(pending), 32'h4);
      tick();
      check("rst_mid_intr_up", 32'(intr), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_intr", 32'(intr), 0);
      check("rst_mid_pend0", 32'(pending), 0);
      check("rst_mid_busy", 32'(busy), 0);
      repeat (5) tick();
      check("rst_mid_quiet", 32'(intr), 0);

      // Single source: latency, ack clear, holdoff length.
      irq_set = 4'b0001;
      exp_q.push_back(0);
      tick();
      irq_set = '0;
      check("single_pending", 32'(pending), 32'h1);
      check("single_latency", 32'(intr), 0);
      tick();
      check("single_intr", 32'(intr), 1);
      check("single_vector", 32'(vector), 0);
      do_ack();
      check("single_ack_intr", 32'(intr), 0);
      check("single_ack_pend", 32'(pending), 0);
      check("single_hold1", 32'(busy), 1);
      tick();
      check("single_hold2", 32'(busy), 1);
      tick();
      check("single_idle", 32'(busy), 0);

      // Round-robin fairness from rr_ptr=0.
      do_reset();
      irq_mask = 4'b1111;
      irq_set  = 4'b1111;
      for (int v = 0; v < N_SRC; v++) exp_q.push_back(VEC_W'(v));
      tick();
      irq_set = '0;
      for (int v = 0; v < N_SRC; v++) begin
         wait_intr("rr_wait", n);
         repeat (2) tick();
         do_ack();
      end
      wait_idle();
      check("rr_final_pend", 32'(pending), 0);

      // Masking: only source 2 first, then source 1 via pointer wrap.
      irq_mask = 4'b0100;
      irq_set  = 4'b0110;
      exp_q.push_back(2);
      tick();
      irq_set = '0;
      wait_intr("mask_wait2", n);
      check("mask_vec2", 32'(vector), 2);
      do_ack();
      check("mask_pend", 32'(pending), 32'h2);
      irq_mask = 4'b0110;
      exp_q.push_back(1);
      wait_intr("mask_wait1", n);
      check("mask_vec1", 32'(vector), 1);
      do_ack();

      // Set/clear collision on source 1: re-serviced after exactly HOLDOFF+1.
      wait_idle();
      irq_mask = 4'b1111;
      irq_set  = 4'b0010;
      exp_q.push_back(1);
      tick();
      irq_set = '0;
      wait_intr("coll_wait", n);
      irq_set  = 4'b0010;
      exp_q.push_back(1);
      do_ack();
      irq_set = '0;
      check("coll_pend_kept", 32'(pending), 32'h2);
      wait_intr("coll_rewait", n);
      check("coll_spacing", 32'(n), 32'(HOLDOFF + 1));
      check("coll_vector", 32'(vector), 1);
      do_ack();
      check("coll_pend_clr", 32'(pending), 0);

      // Stray ack in IDLE changes nothing.
      wait_idle();
      irq_mask = 4'b0000;
      irq_set  = 4'b1000;
      tick();
      irq_set = '0;
      repeat (2) tick();
      do_ack();
      check("stray_pend", 32'(pending), 32'h8);
      repeat (3) tick();
      check("stray_intr", 32'(intr), 0);
      // rr_ptr is 2 after servicing 1: with 0 and 3 pending, 3 goes first.
      irq_set = 4'b0001;
      tick();
      irq_set  = '0;
      irq_mask = 4'b1111;
      exp_q.push_back(3);
      exp_q.push_back(0);
      for (int v = 0; v < 2; v++) begin
         wait_intr("stray_wait", n);
         do_ack();
      end
      wait_idle();
      repeat (3) tick();
      check("final_pend", 32'(pending), 0);
      check("sb_drained", 32'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
